// File: rtl/config_3d_register_bank.sv
// config_3d_register_bank: JTAG DR bank of N_REGS config registers with framed access, sticky lock and error flag
module config_3d_register_bank #(
   parameter int                   DW           = 8,
   parameter int                   N_REGS       = 4,
   parameter int                   AW           = 2,
   parameter logic [N_REGS*DW-1:0] RESET_FLAT   = 32'h0000_0001,
   parameter logic [3:0]           TAPCONFIG_OP = 4'b0011
)(
   input  logic                 TCK,
   input  logic                 TRST_N,
   input  logic                 TDI,
   input  logic [3:0]           tap_state,
   input  logic [3:0]           IR,
   output logic [N_REGS*DW-1:0] config_flat,
   output logic                 config_tdo,
   output logic                 cfg_wr_pulse,
   output logic                 cfg_locked,
   output logic                 cfg_err
);
   localparam int FW = 1 + AW + DW;
   localparam int CW = $clog2(FW + 2);
   localparam logic [CW-1:0] FW_C   = CW'(FW);
   localparam logic [CW-1:0] FW_SAT = CW'(FW + 1);
   localparam logic [AW:0]   NR     = (AW+1)'(N_REGS);
   localparam logic [3:0] TLR        = 4'b1111;
   localparam logic [3:0] CAPTURE_DR = 4'b0110;
   localparam logic [3:0] SHIFT_DR   = 4'b0010;
   localparam logic [3:0] UPDATE_DR  = 4'b0101;
   logic [DW-1:0] r_regs [N_REGS];
   logic [FW-1:0] r_shift;
   logic [AW-1:0] r_rd_addr;
   logic [CW-1:0] r_bitcnt;
   logic          r_lock;
   logic          r_err;
   logic          r_wr_pulse;
   logic          w_sel;
   logic          w_wr;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   assign w_sel  = IR == TAPCONFIG_OP;
   assign w_wr   = r_shift[FW-1];
   assign w_addr = r_shift[FW-2:DW];
   assign w_data = r_shift[DW-1:0];
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) begin
         for (int i = 0; i < N_REGS; i++) r_regs[i] <= RESET_FLAT[i*DW +: DW];
         r_shift    <= '0;
         r_rd_addr  <= '0;
         r_bitcnt   <= '0;
         r_lock     <= 1'b0;
         r_err      <= 1'b0;
         r_wr_pulse <= 1'b0;
      end else if (tap_state == TLR) begin
         for (int i = 0; i < N_REGS; i++) r_regs[i] <= RESET_FLAT[i*DW +: DW];
         r_shift    <= '0;
         r_rd_addr  <= '0;
         r_bitcnt   <= '0;
         r_lock     <= 1'b0;
         r_err      <= 1'b0;
         r_wr_pulse <= 1'b0;
      end else begin
         r_wr_pulse <= 1'b0;
         // err is cleared on capture but its old value rides out in the frame
         if (w_sel && tap_state == CAPTURE_DR) begin
            r_shift  <= {r_err, r_rd_addr, r_regs[r_rd_addr]};
            r_bitcnt <= '0;
            r_err    <= 1'b0;
         end
         if (w_sel && tap_state == SHIFT_DR) begin
            r_shift <= {TDI, r_shift[FW-1:1]};
            if (r_bitcnt != FW_SAT) r_bitcnt <= r_bitcnt + 1'b1;
         end
         if (w_sel && tap_state == UPDATE_DR) begin
            if (r_bitcnt != FW_C || {1'b0, w_addr} >= NR) r_err <= 1'b1;
            else begin
               r_rd_addr <= w_addr;
               if (w_wr && r_lock) r_err <= 1'b1;
               else if (w_wr) begin
                  r_regs[w_addr] <= w_data;
                  r_wr_pulse     <= 1'b1;
                  if (w_addr == '0 && w_data[DW-1]) r_lock <= 1'b1;
               end
            end
         end
      end
   end
   for (genvar g = 0; g < N_REGS; g++) begin : g_flat
      assign config_flat[g*DW +: DW] = r_regs[g];
   end
   assign config_tdo   = r_shift[0];
   assign cfg_wr_pulse = r_wr_pulse;
   assign cfg_locked   = r_lock;
   assign cfg_err      = r_err;
endmodule

// File: tb/tb_config_3d_register_bank.sv
// tb_config_3d_register_bank: directed scans against a 4-register and a 3-register bank
module tb_config_3d_register_bank;
   localparam logic [3:0] TLR  = 4'b1111;
   localparam logic [3:0] CAP  = 4'b0110;
   localparam logic [3:0] SHF  = 4'b0010;
   localparam logic [3:0] UPD  = 4'b0101;
   localparam logic [3:0] IDLE = 4'b1100;
   logic        TCK = 1'b0;
   logic        TRST_N = 1'b0;
   logic        TDI = 1'b0;
   logic [3:0]  tap_state = IDLE;
   logic [3:0]  ir_a = 4'b0000;
   logic [3:0]  ir_b = 4'b0000;
   logic [31:0] flat_a;
   logic [23:0] flat_b;
   logic        tdo_a, pulse_a, lock_a, err_a;
   logic        tdo_b, pulse_b, lock_b, err_b;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [10:0] s_out;
   logic        s_err_cap, s_pulse_u, s_err_u, s_pulse_n;
   always #5 TCK = ~TCK;
   config_3d_register_bank u_dut_a (
      .TCK(TCK), .TRST_N(TRST_N), .TDI(TDI), .tap_state(tap_state), .IR(ir_a),
      .config_flat(flat_a), .config_tdo(tdo_a), .cfg_wr_pulse(pulse_a),
      .cfg_locked(lock_a), .cfg_err(err_a)
   );
   config_3d_register_bank #(.N_REGS(3), .RESET_FLAT(24'h000001)) u_dut_b (
      .TCK(TCK), .TRST_N(TRST_N), .TDI(TDI), .tap_state(tap_state), .IR(ir_b),
      .config_flat(flat_b), .config_tdo(tdo_b), .cfg_wr_pulse(pulse_b),
      .cfg_locked(lock_b), .cfg_err(err_b)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick(input logic [3:0] st, input logic d);
      tap_state = st;
      TDI = d;
      @(posedge TCK);
      #1;
   endtask
   // full DR scan: capture, nbits shifts (LSB first), update, idle
   task automatic scan(input logic b, input int nbits, input logic [10:0] frame);
      s_out = '0;
      tick(CAP, 1'b0);
      s_err_cap = b ? err_b : err_a;
      for (int i = 0; i < nbits; i++) begin
         s_out[i] = b ? tdo_b : tdo_a;
         tick(SHF, frame[i]);
      end
      tick(UPD, 1'b0);
      s_pulse_u = b ? pulse_b : pulse_a;
      s_err_u   = b ? err_b : err_a;
      tick(IDLE, 1'b0);
      s_pulse_n = b ? pulse_b : pulse_a;
   endtask
   initial begin
      repeat (3) @(posedge TCK);
      #1 TRST_N = 1'b1;
      tick(IDLE, 1'b0);
      chk("rst_flat", flat_a, 32'h0000_0001);
      chk("rst_lock", 32'(lock_a), 32'd0);
      chk("rst_err", 32'(err_a), 32'd0);
      chk("rst_tdo", 32'(tdo_a), 32'd0);
      chk("rst_pulse", 32'(pulse_a), 32'd0);
      chk("rst_flat_b", 32'(flat_b), 32'h0000_0001);
      ir_a = 4'b0011;
      scan(1'b0, 11, 11'h6A5);
      chk("wr2_capture", 32'(s_out), 32'h001);
      chk("wr2_pulse", 32'(s_pulse_u), 32'd1);
      chk("wr2_pulse_off", 32'(s_pulse_n), 32'd0);
      chk("wr2_flat", flat_a, 32'h00A5_0001);
      chk("wr2_err", 32'(err_a), 32'd0);
      scan(1'b0, 11, 11'h200);
      chk("rd2_capture", 32'(s_out), 32'h2A5);
      chk("rd2_nopulse", 32'(s_pulse_u), 32'd0);
      scan(1'b0, 11, 11'h200);
      chk("rd2_third", 32'(s_out), 32'h2A5);
      scan(1'b0, 10, 11'h5FF);
      chk("short_err", 32'(s_err_u), 32'd1);
      chk("short_nopulse", 32'(s_pulse_u), 32'd0);
      chk("short_flat", flat_a, 32'h00A5_0001);
      scan(1'b0, 11, 11'h200);
      chk("short_errout", 32'(s_out), 32'h6A5);
      chk("short_errclr", 32'(s_err_cap), 32'd0);
      chk("short_errstay", 32'(s_err_u), 32'd0);
      scan(1'b0, 11, 11'h481);
      chk("lock_capture", 32'(s_out), 32'h2A5);
      chk("lock_pulse", 32'(s_pulse_u), 32'd1);
      chk("lock_flat", flat_a, 32'h00A5_0081);
      chk("lock_set", 32'(lock_a), 32'd1);
      scan(1'b0, 11, 11'h53C);
      chk("locked_capture", 32'(s_out), 32'h081);
      chk("locked_nopulse", 32'(s_pulse_u), 32'd0);
      chk("locked_err", 32'(s_err_u), 32'd1);
      chk("locked_flat", flat_a, 32'h00A5_0081);
      scan(1'b0, 11, 11'h100);
      chk("locked_rd1", 32'(s_out), 32'h500);
      chk("locked_errclr", 32'(s_err_cap), 32'd0);
      scan(1'b0, 11, 11'h100);
      chk("locked_rd1_again", 32'(s_out), 32'h100);
      scan(1'b0, 10, 11'h3FF);
      scan(1'b0, 10, 11'h3FF);
      chk("pre_ir_err", 32'(err_a), 32'd1);
      chk("pre_ir_tdo", 32'(tdo_a), 32'd1);
      ir_a = 4'b0001;
      scan(1'b0, 11, 11'h2AA);
      chk("ir_tdo_hold", 32'(tdo_a), 32'd1);
      chk("ir_err_hold", 32'(err_a), 32'd1);
      chk("ir_flat_hold", flat_a, 32'h00A5_0081);
      chk("ir_lock_hold", 32'(lock_a), 32'd1);
      chk("ir_nopulse", 32'(s_pulse_u), 32'd0);
      ir_a = 4'b0000;
      ir_b = 4'b0011;
      scan(1'b1, 11, 11'h677);
      chk("b_capture", 32'(s_out), 32'h001);
      chk("b_wr_pulse", 32'(s_pulse_u), 32'd1);
      chk("b_wr_flat", 32'(flat_b), 32'h0077_0001);
      scan(1'b1, 11, 11'h755);
      chk("b_oob_err", 32'(s_err_u), 32'd1);
      chk("b_oob_nopulse", 32'(s_pulse_u), 32'd0);
      chk("b_oob_flat", 32'(flat_b), 32'h0077_0001);
      tick(TLR, 1'b0);
      chk("tlr_flat_b", 32'(flat_b), 32'h0000_0001);
      chk("tlr_err_b", 32'(err_b), 32'd0);
      chk("tlr_lock_b", 32'(lock_b), 32'd0);
      chk("tlr_flat_a", flat_a, 32'h0000_0001);
      chk("tlr_lock_a", 32'(lock_a), 32'd0);
      chk("tlr_err_a", 32'(err_a), 32'd0);
      chk("tlr_tdo_a", 32'(tdo_a), 32'd0);
      ir_a = 4'b0011;
      ir_b = 4'b0000;
      tick(CAP, 1'b0);
      for (int i = 0; i < 5; i++) tick(SHF, 1'b1);
      TRST_N = 1'b0;
      #2 TRST_N = 1'b1;
      tick(UPD, 1'b0);
      chk("trst_nopulse", 32'(pulse_a), 32'd0);
      chk("trst_err", 32'(err_a), 32'd1);
      tick(IDLE, 1'b0);
      chk("trst_flat", flat_a, 32'h0000_0001);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
